// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

endpackage

// File: rtl/shift_seq_step.sv
// Combinational single-bit right shift: sign fill (arithmetic) or zero fill (logical).
module shift_seq_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  output logic [WIDTH-1:0] data_out,
  output logic             shifted_out
);

  logic fill;

  assign fill        = (mode == MODE_LOGIC) ? 1'b0 : data_in[WIDTH-1];
  assign data_out    = {fill, data_in[WIDTH-1:1]};
  assign shifted_out = data_in[0];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle right shifter: one bit per cycle with a valid/ready handshake on both sides.
// Defining SHIFT_SEQ_STICKY_EN adds a sticky output (OR of all bits shifted out).
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    amount,
  input  logic             mode,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef SHIFT_SEQ_STICKY_EN
  ,
  output logic             sticky
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] step_out;
  logic             step_lost;
  logic             mode_q;
  logic [AW-1:0]    count_q;
  logic             accept;

  assign start_ready  = (state_q == IDLE);
  assign accept       = start_valid & start_ready;
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign result       = work_q;

  shift_seq_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .data_in    (work_q),
    .mode       (mode_q),
    .data_out   (step_out),
    .shifted_out(step_lost)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the default at the top keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (amount == '0) ? DONE : SHIFT;
      SHIFT:   if (count_q == AW'(1)) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so the result reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      mode_q  <= MODE_ARITH;
      count_q <= '0;
    end else if (accept) begin
      work_q  <= data_in;
      mode_q  <= mode;
      count_q <= amount;
    end else if (state_q == SHIFT) begin
      work_q  <= step_out;
      count_q <= count_q - AW'(1);
    end
  end

`ifdef SHIFT_SEQ_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sticky_q <= 1'b0;
    else if (accept)            sticky_q <= 1'b0;
    else if (state_q == SHIFT)  sticky_q <= sticky_q | step_lost;
  end

  assign sticky = sticky_q;
`else
  logic unused_lost;
  assign unused_lost = step_lost;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_shift_sequencer;

  localparam int W  = 16;
  localparam int AW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  logic [W-1:0]  data_in;
  logic [AW-1:0] amount;
  logic          mode;
  logic          result_valid;
  logic          result_ready;
  logic [W-1:0]  result;
  logic          busy;
`ifdef SHIFT_SEQ_STICKY_EN
  logic          sticky;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  shift_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .data_in     (data_in),
    .amount      (amount),
    .mode        (mode),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result      (result),
    .busy        (busy)
`ifdef SHIFT_SEQ_STICKY_EN
    ,
    .sticky      (sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: full shift by amt at once.
  function automatic logic [W-1:0] model_shift(input logic [W-1:0] d, input int amt, input logic m);
    logic signed [W-1:0] s;
    s = d;
    if (m) return d >> amt;
    else   return s >>> amt;
  endfunction

  function automatic logic model_sticky(input logic [W-1:0] d, input int amt);
    logic [W-1:0] mask;
    mask = (W'(1) << amt) - W'(1);
    return (d & mask) != '0;
  endfunction

  task automatic scramble_inputs();
    start_valid  = 1'($urandom);
    data_in      = W'($urandom);
    amount       = AW'($urandom);
    mode         = 1'($urandom);
    result_ready = 1'($urandom);
  endtask

  task automatic do_op(input logic [W-1:0] d, input int amt, input logic m, input int hold);
    logic [W-1:0] exp_res;
    int           lat;
    bit           done;
    exp_res = model_shift(d, amt, m);

    @(negedge clk);
    check("start_ready_idle", start_ready, 1);
    start_valid  = 1'b1;
    data_in      = d;
    amount       = AW'(amt);
    mode         = m;
    result_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    #1 scramble_inputs();

    done = 0;
    while (!done && lat <= W + 4) begin
      @(negedge clk);
      if (result_valid) begin
        done = 1;
      end else begin
        check("busy_shift", busy, 1);
        check("start_ready_shift", start_ready, 0);
        @(posedge clk);
        lat++;
        #1 scramble_inputs();
      end
    end
    result_ready = 1'b0;
    start_valid  = 1'b0;
    if (!done) begin
      check("valid_timeout", result_valid, 1);
      return;
    end

    check("latency", lat, amt + 1);
    check("result", result, exp_res);
    check("busy_done", busy, 1);
    check("start_ready_done", start_ready, 0);
`ifdef SHIFT_SEQ_STICKY_EN
    check("sticky", sticky, model_sticky(d, amt));
`endif

    repeat (hold) begin
      start_valid = 1'($urandom);
      data_in     = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_result", result, exp_res);
      check("hold_start_ready", start_ready, 0);
    end

    // Offer a request during the handshake cycle; it must not be taken.
    start_valid  = 1'b1;
    data_in      = W'($urandom);
    amount       = AW'(1);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    check("idle_valid", result_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_start_ready", start_ready, 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    start_valid  = 1'b0;
    data_in      = '0;
    amount       = '0;
    mode         = 1'b0;
    result_ready = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_start_ready", start_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h8000, 3, 1'b0, 0);
    do_op(16'h8000, 3, 1'b1, 1);
    do_op(16'h1234, 0, 1'b0, 0);
    do_op(16'h1234, 0, 1'b1, 2);
    do_op(16'hFFFF, 15, 1'b1, 5);
    do_op(16'hFFFF, 15, 1'b0, 0);

    // Reset in the middle of a shift aborts the operation.
    @(negedge clk);
    start_valid = 1'b1;
    data_in     = 16'hABCD;
    amount      = AW'(10);
    mode        = 1'b0;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", result_valid, 0);
    check("abort_result", result, 0);
    check("abort_start_ready", start_ready, 1);
`ifdef SHIFT_SEQ_STICKY_EN
    check("abort_sticky", sticky, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    do_op(16'h00F0, 4, 1'b1, 0);

    do_op(16'h0007, 2, 1'b1, 0);
    do_op(16'h0004, 2, 1'b1, 0);
    do_op(16'h0004, 2, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data width in bits (>= 2, power of two).
REQ-002 SHALL have derived constant: AW = $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start_valid  input  1  request present.
REQ-006 SHALL have port: start_ready  output  1  block can accept request.
REQ-007 SHALL have port: data_in  input  WIDTH  operand to shift.
REQ-008 SHALL have port: amount  input  AW  right-shift count, 0..WIDTH-1.
REQ-009 SHALL have port: mode  input  1  0 = arithmetic (sign fill), 1 = logical (zero fill).
REQ-010 SHALL have port: result_valid  output  1  result available.
REQ-011 SHALL have port: result_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: result  output  WIDTH  shifted operand.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL assert start_ready only in IDLE; accept = start_valid & start_ready.
REQ-016 SHALL on accept latch data_in, mode, and amount into internal registers; later input changes have no effect.
REQ-017 SHALL on accept with amount = 0 go IDLE->DONE, with result = data_in (latency 1 cycle).
REQ-018 SHALL on accept with amount = k > 0 go IDLE->SHIFT with count = k.
REQ-019 SHALL in SHIFT shift the working register right by exactly 1 bit per cycle using latched mode, and decrement count.
REQ-020 SHALL leave SHIFT for DONE on the cycle that count goes 1->0; result_valid first high k+1 cycles after accept edge.
REQ-021 SHALL in DONE hold result_valid = 1 and result stable until result_ready = 1 (handshake), then go DONE->IDLE.
REQ-022 SHALL NOT accept a new request in the handshake cycle; next accept is earliest one cycle after DONE->IDLE.
REQ-023 SHALL produce, for arithmetic mode, MSB replication per step; for logical mode, zero insertion per step.
REQ-024 SHALL ignore result_ready outside DONE and start_valid outside IDLE.

Reset
REQ-025 SHALL on rst_n = 0 immediately force state IDLE, result = 0, count = 0, result_valid = 0, busy = 0, start_ready = 1 after release.
REQ-026 SHALL abort any in-flight operation on reset with no result produced.

Configuration
REQ-027 SHALL with macro SHIFT_SEQ_STICKY_EN defined add output port sticky (1 bit): OR of all bits shifted out during the operation, valid with result_valid, cleared on accept and on reset.
REQ-028 SHALL without SHIFT_SEQ_STICKY_EN omit the sticky port and its logic entirely; all other behaviour identical.

Structure
REQ-029 SHALL place in package shift_seq_pkg: state enum (IDLE, SHIFT, DONE) and mode constants MODE_ARITH = 0, MODE_LOGIC = 1.
REQ-030 SHALL instantiate one sub-module shift_seq_step: combinational single-bit right shift (WIDTH param, in, mode -> out, shifted-out bit).

Verification
REQ-031 SHALL cover: data_in 0x8000, amount 3, mode 0 -> result 0xF000, result_valid 4 cycles after accept.
REQ-032 SHALL cover: data_in 0x8000, amount 3, mode 1 -> result 0x1000.
REQ-033 SHALL cover: data_in 0x1234, amount 0 -> result 0x1234, result_valid 1 cycle after accept.
REQ-034 SHALL cover: data_in 0xFFFF, amount 15, mode 1, result_ready low 5 cycles -> result 0x0001 held stable, start_ready low throughout, IDLE one cycle after handshake.
REQ-035 SHALL cover: rst_n pulsed low mid-SHIFT -> busy and result_valid low, result 0x0000, next request 0x00F0 amount 4 mode 1 -> 0x000F.
REQ-036 SHALL cover (SHIFT_SEQ_STICKY_EN): data_in 0x0007, amount 2, mode 1 -> result 0x0001, sticky 1; data_in 0x0004, amount 2 -> sticky 0.
